// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, widths and magnitude helper for the Sobel stream filter
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;
  localparam int GRAD_W    = PIX_W_DEF + 3;
  localparam int CNT_W     = $clog2((IMG_W_DEF > IMG_H_DEF) ? IMG_W_DEF : IMG_H_DEF);

  function automatic int cnt_width(input int w, input int h);
    return $clog2((w > h) ? w : h);
  endfunction

  // |gx|+|gy| clipped to the largest value a pix_w-bit pixel can hold
  function automatic int sat_mag(input int gx, input int gy, input int pix_w);
    int ax;
    int ay;
    int mag;
    int lim;
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    lim = (1 << pix_w) - 1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/sobel_stream_filter_line_buffer.sv
// rtl/sobel_stream_filter_line_buffer.sv - two cascaded one-line delays sharing one pointer
// tap1 is the sample from DEPTH advances ago, tap2 from 2*DEPTH advances ago.
module sobel_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap1,
  output logic [WIDTH-1:0] tap2
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem1_q [DEPTH];
  logic [WIDTH-1:0] mem2_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Slot ptr_q holds the oldest sample; it is read out and overwritten on the same advance
  always_ff @(posedge clk) begin
    if (adv) begin
      mem1_q[ptr_q] <= din;
      mem2_q[ptr_q] <= mem1_q[ptr_q];
    end
  end

  assign tap1 = mem1_q[ptr_q];
  assign tap2 = mem2_q[ptr_q];

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 Sobel |Gx|+|Gy| filter, valid/ready both sides
// Define SOBEL_THRESHOLD_EN to binarise the magnitude against thresh.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] m_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  input  logic [PIX_W-1:0] thresh
);
  localparam int GW = PIX_W + 3;
  localparam int CW = cnt_width(IMG_W, IMG_H);
  localparam logic [CW:0] WARM = (CW + 1)'(IMG_W + 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          irow_q, irow_d, icol_q, icol_d;
  logic [CW-1:0]          orow_q, orow_d, ocol_q, ocol_d;
  logic [CW:0]            warm_q, warm_d;
  logic [2:0][PIX_W-1:0]  col0_q, col0_d, col1_q, col1_d;
  logic [PIX_W-1:0]       m_pixel_q, m_pixel_d;
  logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic                   can_adv, adv, in_last, out_last, out_border;
  logic [PIX_W-1:0]       din, tap1, tap2, mag_sat, pix;
  logic signed [GW-1:0]   gx, gy;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lines (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (adv),
    .din  (din),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  assign can_adv    = !m_valid_q || m_ready;
  assign s_ready    = (state_q == RUN) && can_adv;
  assign busy       = (state_q != IDLE);
  assign in_last    = (irow_q == CW'(IMG_H - 1)) && (icol_q == CW'(IMG_W - 1));
  assign out_last   = (orow_q == CW'(IMG_H - 1)) && (ocol_q == CW'(IMG_W - 1));
  assign out_border = (orow_q == '0) || (orow_q == CW'(IMG_H - 1)) ||
                      (ocol_q == '0) || (ocol_q == CW'(IMG_W - 1));

  // Flush advances feed zeros until the final output has been loaded
  always_comb begin
    adv = 1'b0;
    din = '0;
    if (state_q == RUN) begin
      adv = s_valid && can_adv;
      din = s_pixel;
    end else if (state_q == FLUSH) begin
      adv = can_adv && !(m_valid_q && m_last_q);
    end
  end

  // Window columns: col0 = c-1, col1 = c, incoming {din,tap1,tap2} = c+1; index 0 is the top row
  always_comb begin
    gx = (ext(tap2) + (ext(tap1) <<< 1) + ext(din)) -
         (ext(col0_q[0]) + (ext(col0_q[1]) <<< 1) + ext(col0_q[2]));
    gy = (ext(col0_q[2]) + (ext(col1_q[2]) <<< 1) + ext(din)) -
         (ext(col0_q[0]) + (ext(col1_q[0]) <<< 1) + ext(tap2));
    mag_sat = PIX_W'(sat_mag(int'(gx), int'(gy), PIX_W));
`ifdef SOBEL_THRESHOLD_EN
    pix = (mag_sat >= thresh) ? '1 : '0;
`else
    pix = mag_sat;
`endif
  end

`ifndef SOBEL_THRESHOLD_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  always_comb begin
    state_d   = state_q;
    irow_d    = irow_q;
    icol_d    = icol_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    warm_d    = warm_q;
    col0_d    = col0_q;
    col1_d    = col1_q;
    m_pixel_d = m_pixel_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (adv) begin
      col0_d = col1_q;
      col1_d = {din, tap1, tap2};
      if (warm_q != WARM) begin
        warm_d = warm_q + 1'b1;
      end else begin
        m_valid_d = 1'b1;
        m_pixel_d = out_border ? '0 : pix;
        m_last_d  = out_last;
        if (ocol_q == CW'(IMG_W - 1)) begin
          ocol_d = '0;
          orow_d = out_last ? '0 : orow_q + 1'b1;
        end else begin
          ocol_d = ocol_q + 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          irow_d  = '0;
          icol_d  = '0;
          orow_d  = '0;
          ocol_d  = '0;
          warm_d  = '0;
        end
      end
      RUN: begin
        if (adv) begin
          if (icol_q == CW'(IMG_W - 1)) begin
            icol_d = '0;
            irow_d = in_last ? '0 : irow_q + 1'b1;
          end else begin
            icol_d = icol_q + 1'b1;
          end
          if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (m_valid_q && m_ready && m_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irow_q    <= '0;
      icol_q    <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      warm_q    <= '0;
      col0_q    <= '0;
      col1_q    <= '0;
      m_pixel_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      irow_q    <= irow_d;
      icol_q    <= icol_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      warm_q    <= warm_d;
      col0_q    <= col0_d;
      col1_q    <= col1_d;
      m_pixel_q <= m_pixel_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_pixel = m_pixel_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule
